// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM->WB valid/ready stage with optional 2-entry skid buffer,
// flush, run gating and a saturating back-pressure cycle counter.
module mem_wb_skid_stage #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 12,
    parameter int RD_W    = 5,
    parameter int SKID    = 1,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_en,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_mem_read_data,
    input  logic [DATA_W-1:0]  in_alu_result,
    input  logic [PC_W-1:0]    in_pc_plus_4,
    input  logic [RD_W-1:0]    in_rd,
    input  logic [3:0]         in_ctrl,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_mem_read_data,
    output logic [DATA_W-1:0]  out_alu_result,
    output logic [PC_W-1:0]    out_pc_plus_4,
    output logic [RD_W-1:0]    out_rd,
    output logic [3:0]         out_ctrl,
    output logic [STALL_W-1:0] stall_cycles
);
    localparam int W = 2 * DATA_W + PC_W + RD_W + 4;

    logic [W-1:0]       in_bus, main_q, main_d, skid_q, skid_d;
    logic               out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, rdy_q, rdy_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [3:0]         ctrl_raw;
    logic               accept, drain;

    assign in_bus = {in_mem_read_data, in_alu_result, in_pc_plus_4, in_rd, in_ctrl};
    // rdy_q is a registered "skid empty" flag; it is 0 out of reset so in_ready stays low until the first edge
    assign in_ready = run_en && rdy_q && (SKID != 0 || !out_valid_q || out_ready);
    assign accept = in_valid && in_ready;
    assign drain = run_en && out_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        rdy_d        = rdy_q;
        stall_d      = stall_q;
        if (run_en) begin
            if (flush) begin
                out_valid_d  = 1'b0;
                skid_valid_d = 1'b0;
            end else if (skid_valid_q && drain) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept && (!out_valid_q || drain)) begin
                main_d      = in_bus;
                out_valid_d = 1'b1;
            end else if (accept) begin
                skid_d       = in_bus;
                skid_valid_d = 1'b1;
            end else if (drain) begin
                out_valid_d = 1'b0;
            end
            rdy_d = !skid_valid_d;
            if (out_valid_q && !out_ready && !flush && stall_q != '1)
                stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            rdy_q        <= 1'b0;
            stall_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            rdy_q        <= rdy_d;
            stall_q      <= stall_d;
        end
    end

    assign {out_mem_read_data, out_alu_result, out_pc_plus_4, out_rd, ctrl_raw} = main_q;
    assign out_ctrl     = out_valid_q ? ctrl_raw : 4'b0;
    assign out_valid    = out_valid_q;
    assign stall_cycles = stall_q;
endmodule
